// File: rtl/spi_byte_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_engine
// Description : Single-byte SPI master, mode 0 (CPOL=0, CPHA=0). Each accepted
//               byte is sent as one chip-select frame: CS setup, 16 SCK edges,
//               CS hold, then an optional CS-inactive gap before the engine
//               accepts the next byte.
// Parameters  : CLKS_PER_HALF_BIT  clk cycles per SCK half-period (1..255)
//               CS_INACTIVE_CLKS   minimum cs_n-high cycles between frames (0..255)
// Macro       : SPI_LOOPBACK_EN    adds i_loopback; when high the receive
//                                  sampler takes the internal mosi, not i_miso
// Ports       : clk, rst (async, active-high)
//               i_tx_byte/i_tx_dv/o_tx_ready  byte request handshake
//               o_rx_dv/o_rx_byte             received byte, one-cycle strobe
//               o_busy                        inverse of o_tx_ready
//               o_sck/o_mosi/i_miso/o_cs_n    SPI pins
// Revision    : 1.0  initial release
// ============================================================================
module spi_byte_engine #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_busy,
  output logic       o_sck,
  output logic       o_mosi,
  input  logic       i_miso,
`ifdef SPI_LOOPBACK_EN
  input  logic       i_loopback,
`endif
  output logic       o_cs_n
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CS_SETUP = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] CS_HOLD  = 3'd3;
  localparam logic [2:0] CS_GAP   = 3'd4;

  // Terminal counts; 8 bits covers a half-period of 255 clocks without wrap.
  localparam logic [7:0] c_HALF_LAST = 8'(CLKS_PER_HALF_BIT - 1);
  localparam logic [7:0] c_GAP_LAST  = 8'(CS_INACTIVE_CLKS - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_edge;     // SCK edges already produced in this frame
  logic       r_sck;
  logic       r_mosi;
  logic       r_cs_n;
  logic [7:0] r_tx_sr;
  logic [7:0] r_rx_sr;
  logic [7:0] r_rx_byte;
  logic       r_rx_dv;

  logic w_half_done;
  logic w_rx_in;

  assign w_half_done = (r_cnt == c_HALF_LAST);

`ifdef SPI_LOOPBACK_EN
  assign w_rx_in = i_loopback ? r_mosi : i_miso;
`else
  assign w_rx_in = i_miso;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_edge    <= 4'd0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_tx_sr   <= 8'd0;
      r_rx_sr   <= 8'd0;
      r_rx_byte <= 8'd0;
      r_rx_dv   <= 1'b0;
    end else begin
      r_rx_dv <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt  <= 8'd0;
          r_edge <= 4'd0;
          if (i_tx_dv) begin
            // Bit 7 is presented together with the falling cs_n.
            r_tx_sr <= i_tx_byte;
            r_mosi  <= i_tx_byte[7];
            r_cs_n  <= 1'b0;
            r_state <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          if (w_half_done) begin
            r_cnt   <= 8'd0;
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        // SCK stays low for the first half-period here, so the first rising
        // edge lands a full half-period after setup ends.
        SHIFT: begin
          if (w_half_done) begin
            r_cnt  <= 8'd0;
            r_sck  <= ~r_sck;
            r_edge <= r_edge + 4'd1;
            if (!r_sck) begin
              r_rx_sr <= {r_rx_sr[6:0], w_rx_in};
            end else if (r_edge != 4'd15) begin
              r_tx_sr <= r_tx_sr << 1;
              r_mosi  <= r_tx_sr[6];
            end
            // Final falling edge: all 8 samples were taken on the rising
            // edge before it, so the byte can be published now.
            if (r_edge == 4'd15) begin
              r_rx_byte <= r_rx_sr;
              r_rx_dv   <= 1'b1;
              r_state   <= CS_HOLD;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        CS_HOLD: begin
          if (w_half_done) begin
            r_cnt   <= 8'd0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= (CS_INACTIVE_CLKS == 0) ? IDLE : CS_GAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        CS_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= 8'd0;
          r_cs_n  <= 1'b1;
          r_sck   <= 1'b0;
          r_mosi  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_ready = (r_state == IDLE);
  assign o_busy     = (r_state != IDLE);
  assign o_rx_dv    = r_rx_dv;
  assign o_rx_byte  = r_rx_byte;
  assign o_sck      = r_sck;
  assign o_mosi     = r_mosi;
  assign o_cs_n     = r_cs_n;

endmodule
`default_nettype wire
